bus_control_pipe: RTL and testbench

Parametrised successor to the one-cold bus select decoder. Decodes per-cycle control words into active-low assert, load, address-select and inc/dec strobes for N main-bus devices and M address registers. All outputs are registered. Adds a memory-bridge wait-state handshake with stall, an assert/load contention check, and a timeout watchdog. Sits between the pipeline control stage and the register/device bus.

---
 rtl/bus_control_pipe_pkg.sv | 21 ++
 rtl/bus_control_pipe_if.sv | 45 ++++
 rtl/bus_control_pipe_decoder.sv | 25 ++
 rtl/bus_control_pipe.sv | 182 ++++++++++++++++++
 tb/tb_bus_control_pipe.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/bus_control_pipe_pkg.sv
// Shared types and helpers for the bus control pipe: FSM state encoding,
// a select-width helper and the "no device" select value.
package bus_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int SEL_NONE = 0;

  // Width of a select that indexes n slots; never narrower than one bit.
  function automatic int sel_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/bus_control_pipe_if.sv
// Control-word inputs and decoded bus strobes between the pipeline control
// stage (master) and the bus control pipe (slave).
interface bus_control_pipe_if
  import bus_ctrl_pkg::*;
#(
  parameter int NUM_DEVICES   = 16,
  parameter int NUM_ADDR_REGS = 8
);
  localparam int SEL_W  = sel_width(NUM_DEVICES);
  localparam int ASEL_W = sel_width(NUM_ADDR_REGS);

  logic                     Ctrl_Valid;
  logic [SEL_W-1:0]         Bus_Assert;
  logic [SEL_W-1:0]         Bus_Load;
  logic [ASEL_W-1:0]        Addr_Sel;
  logic [ASEL_W-1:0]        Inc_Sel;
  logic [ASEL_W-1:0]        Dec_Sel;
  logic                     Mem_Ready;
  logic                     Fault_Clear;
  logic [NUM_DEVICES-1:0]   Dev_Assert_n;
  logic [NUM_DEVICES-1:0]   Dev_Load_n;
  logic [NUM_ADDR_REGS-1:0] Addr_Assert_n;
  logic [NUM_ADDR_REGS-1:0] Inc_n;
  logic [NUM_ADDR_REGS-1:0] Dec_n;
  logic                     Mem_Req;
  logic                     Mem_Dir;
  logic                     Stall;
  logic                     Fault_Contention;
  logic                     Fault_Timeout;

  modport master (
    output Ctrl_Valid, Bus_Assert, Bus_Load, Addr_Sel, Inc_Sel, Dec_Sel,
           Mem_Ready, Fault_Clear,
    input  Dev_Assert_n, Dev_Load_n, Addr_Assert_n, Inc_n, Dec_n,
           Mem_Req, Mem_Dir, Stall, Fault_Contention, Fault_Timeout
  );

  modport slave (
    input  Ctrl_Valid, Bus_Assert, Bus_Load, Addr_Sel, Inc_Sel, Dec_Sel,
           Mem_Ready, Fault_Clear,
    output Dev_Assert_n, Dev_Load_n, Addr_Assert_n, Inc_n, Dec_n,
           Mem_Req, Mem_Dir, Stall, Fault_Contention, Fault_Timeout
  );

endinterface

// File: rtl/bus_control_pipe_decoder.sv
// One-cold select decoder: with en high, the selected bit is low; bit 0 is the
// "none" slot and always reads high.
module one_cold_decoder
  import bus_ctrl_pkg::*;
#(
  parameter int N = 16,
  parameter int W = sel_width(N)
) (
  input  logic [W-1:0] sel,
  input  logic         en,
  output logic [N-1:0] y
);

  // Drive a single low bit for the selected slot.
  always_comb begin
    y = {N{1'b1}};
    if (en) begin
      y[sel] = 1'b0;
      y[0]   = 1'b1;
    end else begin
      y = {N{1'b1}};
    end
  end

endmodule

// File: rtl/bus_control_pipe.sv
// Registered bus-control decoder with memory-bridge wait states, assert/load
// contention rejection and a wait-state timeout watchdog.
module bus_control_pipe
  import bus_ctrl_pkg::*;
#(
  parameter int NUM_DEVICES   = 16,
  parameter int NUM_ADDR_REGS = 8,
  parameter int MEM_IDX       = 15,
  parameter int MEM_TIMEOUT   = 64
) (
  input  logic            Clock_In,
  input  logic            Reset_In,
  bus_control_pipe_if.slave bus
);

  localparam int SEL_W  = sel_width(NUM_DEVICES);
  localparam int ASEL_W = sel_width(NUM_ADDR_REGS);
  localparam int CNT_W  = sel_width(MEM_TIMEOUT);
  localparam logic [SEL_W-1:0]  MEM_SEL  = SEL_W'(MEM_IDX);
  localparam logic [SEL_W-1:0]  DEV_NONE = SEL_W'(SEL_NONE);
  localparam logic [ASEL_W-1:0] AR_NONE  = ASEL_W'(SEL_NONE);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [SEL_W-1:0]  lat_assert, lat_load;
  logic [ASEL_W-1:0] lat_addr, lat_inc, lat_dec;
  logic              latch;
  logic              contention, mem_hit;
  logic              en_assert, en_load, en_addr, en_inc, en_dec;
  logic [SEL_W-1:0]  sel_assert, sel_load;
  logic [ASEL_W-1:0] sel_addr, sel_inc, sel_dec;
  logic              req_nx, dir_nx, stall_nx, set_cont, set_to;
  logic [NUM_DEVICES-1:0]   dec_assert, dec_load;
  logic [NUM_ADDR_REGS-1:0] dec_addr, dec_inc, dec_dec;

  assign contention = ((bus.Bus_Assert == bus.Bus_Load) && (bus.Bus_Assert != DEV_NONE)) ||
                      ((bus.Inc_Sel == bus.Dec_Sel) && (bus.Inc_Sel != AR_NONE));
  assign mem_hit    = (bus.Bus_Assert == MEM_SEL) || (bus.Bus_Load == MEM_SEL);

  // While waiting, decode from the latched word; otherwise from the live inputs.
  always_comb begin
    if (state == WAIT) begin
      sel_assert = lat_assert;
      sel_load   = lat_load;
      sel_addr   = lat_addr;
      sel_inc    = lat_inc;
      sel_dec    = lat_dec;
    end else begin
      sel_assert = bus.Bus_Assert;
      sel_load   = bus.Bus_Load;
      sel_addr   = bus.Addr_Sel;
      sel_inc    = bus.Inc_Sel;
      sel_dec    = bus.Dec_Sel;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    latch     = 1'b0;
    en_assert = 1'b0;
    en_load   = 1'b0;
    en_addr   = 1'b0;
    en_inc    = 1'b0;
    en_dec    = 1'b0;
    req_nx    = 1'b0;
    dir_nx    = 1'b0;
    stall_nx  = 1'b0;
    set_cont  = 1'b0;
    set_to    = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.Ctrl_Valid) begin
          state_nx = IDLE;
        end else if (contention) begin
          set_cont = 1'b1;
        end else if (mem_hit) begin
          latch     = 1'b1;
          state_nx  = WAIT;
          cnt_nx    = {CNT_W{1'b0}};
          en_assert = 1'b1;
          en_addr   = 1'b1;
          req_nx    = 1'b1;
          stall_nx  = 1'b1;
          dir_nx    = (bus.Bus_Load == MEM_SEL);
        end else begin
          en_assert = 1'b1;
          en_load   = 1'b1;
          en_addr   = 1'b1;
          en_inc    = 1'b1;
          en_dec    = 1'b1;
        end
      end
      WAIT: begin
        // Completion takes precedence over a coincident timeout.
        if (bus.Mem_Ready) begin
          state_nx  = IDLE;
          cnt_nx    = {CNT_W{1'b0}};
          en_assert = 1'b1;
          en_load   = 1'b1;
          en_addr   = 1'b1;
          en_inc    = 1'b1;
          en_dec    = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = {CNT_W{1'b0}};
          set_to   = 1'b1;
        end else begin
          cnt_nx    = cnt + CNT_W'(1);
          en_assert = 1'b1;
          en_addr   = 1'b1;
          req_nx    = 1'b1;
          stall_nx  = 1'b1;
          dir_nx    = bus.Mem_Dir;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = {CNT_W{1'b0}};
      end
    endcase
  end

  one_cold_decoder #(.N(NUM_DEVICES))   u_dec_assert (.sel(sel_assert), .en(en_assert), .y(dec_assert));
  one_cold_decoder #(.N(NUM_DEVICES))   u_dec_load   (.sel(sel_load),   .en(en_load),   .y(dec_load));
  one_cold_decoder #(.N(NUM_ADDR_REGS)) u_dec_addr   (.sel(sel_addr),   .en(en_addr),   .y(dec_addr));
  one_cold_decoder #(.N(NUM_ADDR_REGS)) u_dec_inc    (.sel(sel_inc),    .en(en_inc),    .y(dec_inc));
  one_cold_decoder #(.N(NUM_ADDR_REGS)) u_dec_dec    (.sel(sel_dec),    .en(en_dec),    .y(dec_dec));

  // FSM, wait counter and latched memory word.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state      <= IDLE;
      cnt        <= {CNT_W{1'b0}};
      lat_assert <= {SEL_W{1'b0}};
      lat_load   <= {SEL_W{1'b0}};
      lat_addr   <= {ASEL_W{1'b0}};
      lat_inc    <= {ASEL_W{1'b0}};
      lat_dec    <= {ASEL_W{1'b0}};
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (latch) begin
        lat_assert <= bus.Bus_Assert;
        lat_load   <= bus.Bus_Load;
        lat_addr   <= bus.Addr_Sel;
        lat_inc    <= bus.Inc_Sel;
        lat_dec    <= bus.Dec_Sel;
      end
    end
  end

  // Output registers; sticky faults give set priority over clear.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      bus.Dev_Assert_n     <= {NUM_DEVICES{1'b1}};
      bus.Dev_Load_n       <= {NUM_DEVICES{1'b1}};
      bus.Addr_Assert_n    <= {NUM_ADDR_REGS{1'b1}};
      bus.Inc_n            <= {NUM_ADDR_REGS{1'b1}};
      bus.Dec_n            <= {NUM_ADDR_REGS{1'b1}};
      bus.Mem_Req          <= 1'b0;
      bus.Mem_Dir          <= 1'b0;
      bus.Stall            <= 1'b0;
      bus.Fault_Contention <= 1'b0;
      bus.Fault_Timeout    <= 1'b0;
    end else begin
      bus.Dev_Assert_n     <= dec_assert;
      bus.Dev_Load_n       <= dec_load;
      bus.Addr_Assert_n    <= dec_addr;
      bus.Inc_n            <= dec_inc;
      bus.Dec_n            <= dec_dec;
      bus.Mem_Req          <= req_nx;
      bus.Mem_Dir          <= dir_nx;
      bus.Stall            <= stall_nx;
      bus.Fault_Contention <= set_cont | (bus.Fault_Contention & ~bus.Fault_Clear);
      bus.Fault_Timeout    <= set_to   | (bus.Fault_Timeout    & ~bus.Fault_Clear);
    end
  end

endmodule

// File: tb/tb_bus_control_pipe.sv
// Directed, table-driven bench for bus_control_pipe (16 devices, 8 address
// registers, memory bridge at 15, timeout of 4 wait cycles).
module tb_bus_control_pipe;

  typedef struct packed {
    logic        valid;
    logic [3:0]  a;
    logic [3:0]  l;
    logic [2:0]  as;
    logic [2:0]  inc;
    logic [2:0]  dec;
    logic        ready;
    logic        clr;
    logic [15:0] e_as;
    logic [15:0] e_ld;
    logic [7:0]  e_ad;
    logic [7:0]  e_in;
    logic [7:0]  e_de;
    logic        e_req;
    logic        e_dir;
    logic        e_stall;
    logic        e_fc;
    logic        e_ft;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  vec_t vecs[$];
  vec_t tmp;

  bus_control_pipe_if #(.NUM_DEVICES(16), .NUM_ADDR_REGS(8)) bif ();

  bus_control_pipe #(
    .NUM_DEVICES(16), .NUM_ADDR_REGS(8), .MEM_IDX(15), .MEM_TIMEOUT(4)
  ) dut (
    .Clock_In(clk),
    .Reset_In(rst),
    .bus(bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bif.Ctrl_Valid  = v.valid;
    bif.Bus_Assert  = v.a;
    bif.Bus_Load    = v.l;
    bif.Addr_Sel    = v.as;
    bif.Inc_Sel     = v.inc;
    bif.Dec_Sel     = v.dec;
    bif.Mem_Ready   = v.ready;
    bif.Fault_Clear = v.clr;
  endtask

  task automatic check(input string tag, input vec_t v);
    chk({tag, " Dev_Assert_n"},  bif.Dev_Assert_n,  v.e_as);
    chk({tag, " Dev_Load_n"},    bif.Dev_Load_n,    v.e_ld);
    chk({tag, " Addr_Assert_n"}, {8'h00, bif.Addr_Assert_n}, {8'h00, v.e_ad});
    chk({tag, " Inc_n"},         {8'h00, bif.Inc_n}, {8'h00, v.e_in});
    chk({tag, " Dec_n"},         {8'h00, bif.Dec_n}, {8'h00, v.e_de});
    chk({tag, " Mem_Req"},       {15'h0000, bif.Mem_Req}, {15'h0000, v.e_req});
    if (v.e_req) begin
      chk({tag, " Mem_Dir"},     {15'h0000, bif.Mem_Dir}, {15'h0000, v.e_dir});
    end
    chk({tag, " Stall"},         {15'h0000, bif.Stall}, {15'h0000, v.e_stall});
    chk({tag, " Fault_Contention"}, {15'h0000, bif.Fault_Contention}, {15'h0000, v.e_fc});
    chk({tag, " Fault_Timeout"}, {15'h0000, bif.Fault_Timeout}, {15'h0000, v.e_ft});
  endtask

  task automatic step(input string tag, input vec_t v);
    apply(v);
    @(posedge clk);
    #1;
    check(tag, v);
  endtask

  localparam logic [15:0] D1 = 16'hFFFF;
  localparam logic [7:0]  A1 = 8'hFF;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    tmp   = vec_t'{1'b0, 4'd0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0,
                   D1, D1, A1, A1, A1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    apply(tmp);
    #2;
    check("reset", tmp);

    //                valid  a      l      as    inc   dec  rdy  clr   assert    load      addr    inc     dec   req  dir  stl  fc   ft
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 0 idle
    vecs.push_back(vec_t'{1'b1,4'd1, 4'd3, 3'd2,3'd1,3'd4,1'b0,1'b0, 16'hFFFD, 16'hFFF7, 8'hFB,  8'hFD,  8'hEF, 1'b0,1'b0,1'b0,1'b0,1'b0}); // 1 plain
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 2
    vecs.push_back(vec_t'{1'b1,4'd15,4'd2, 3'd1,3'd0,3'd0,1'b0,1'b0, 16'h7FFF, D1,       8'hFD,  A1,     A1,    1'b1,1'b0,1'b1,1'b0,1'b0}); // 3 mem read
    vecs.push_back(vec_t'{1'b1,4'd1, 4'd3, 3'd2,3'd1,3'd4,1'b0,1'b0, 16'h7FFF, D1,       8'hFD,  A1,     A1,    1'b1,1'b0,1'b1,1'b0,1'b0}); // 4 ignored word
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, 16'h7FFF, D1,       8'hFD,  A1,     A1,    1'b1,1'b0,1'b1,1'b0,1'b0}); // 5
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b1,1'b0, 16'h7FFF, 16'hFFFB, 8'hFD,  A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 6 done
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 7
    vecs.push_back(vec_t'{1'b1,4'd1, 4'd15,3'd3,3'd2,3'd0,1'b0,1'b0, 16'hFFFD, D1,       8'hF7,  A1,     A1,    1'b1,1'b1,1'b1,1'b0,1'b0}); // 8 mem write
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b1,1'b0, 16'hFFFD, 16'h7FFF, 8'hF7,  8'hFB,  A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 9 done
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b1,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 10 ready in idle
    vecs.push_back(vec_t'{1'b1,4'd5, 4'd5, 3'd2,3'd1,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b1,1'b0}); // 11 contention
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b1,1'b0}); // 12 sticky
    vecs.push_back(vec_t'{1'b1,4'd4, 4'd6, 3'd5,3'd3,3'd1,1'b0,1'b1, 16'hFFEF, 16'hFFBF, 8'hDF,  8'hF7,  8'hFD, 1'b0,1'b0,1'b0,1'b0,1'b0}); // 13 clear+decode
    vecs.push_back(vec_t'{1'b1,4'd1, 4'd2, 3'd0,3'd3,3'd3,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b1,1'b0}); // 14 inc==dec
    vecs.push_back(vec_t'{1'b1,4'd5, 4'd5, 3'd0,3'd0,3'd0,1'b0,1'b1, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b1,1'b0}); // 15 set beats clear
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b1, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 16 clear
    vecs.push_back(vec_t'{1'b1,4'd15,4'd0, 3'd2,3'd0,3'd0,1'b0,1'b0, 16'h7FFF, D1,       8'hFB,  A1,     A1,    1'b1,1'b0,1'b1,1'b0,1'b0}); // 17 timeout run
    for (int k = 0; k < 3; k++)
      vecs.push_back(vec_t'{1'b0,4'd0,4'd0,3'd0,3'd0,3'd0,1'b0,1'b0, 16'h7FFF, D1,       8'hFB,  A1,     A1,    1'b1,1'b0,1'b1,1'b0,1'b0}); // 18-20
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b1}); // 21 timeout
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b1}); // 22 sticky
    vecs.push_back(vec_t'{1'b1,4'd1, 4'd15,3'd0,3'd4,3'd0,1'b0,1'b1, 16'hFFFD, D1,       A1,     A1,     A1,    1'b1,1'b1,1'b1,1'b0,1'b0}); // 23 clear+write
    for (int k = 0; k < 3; k++)
      vecs.push_back(vec_t'{1'b0,4'd0,4'd0,3'd0,3'd0,3'd0,1'b0,1'b0, 16'hFFFD, D1,       A1,     A1,     A1,    1'b1,1'b1,1'b1,1'b0,1'b0}); // 24-26
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b1,1'b0, 16'hFFFD, 16'h7FFF, A1,     8'hEF,  A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 27 ready on last
    vecs.push_back(vec_t'{1'b0,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 28
    vecs.push_back(vec_t'{1'b1,4'd0, 4'd0, 3'd0,3'd0,3'd0,1'b0,1'b0, D1,       D1,       A1,     A1,     A1,    1'b0,1'b0,1'b0,1'b0,1'b0}); // 29 all none

    #10;
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a wait, away from any clock edge.
    step("rw_enter", vec_t'{1'b1,4'd15,4'd2,3'd3,3'd0,3'd0,1'b0,1'b0,
                            16'h7FFF, D1, 8'hF7, A1, A1, 1'b1,1'b0,1'b1,1'b0,1'b0});
    apply(tmp);
    #2;
    rst = 1'b1;
    #1;
    check("rw_reset", tmp);
    #1;
    rst = 1'b0;
    step("rw_after", vec_t'{1'b1,4'd2,4'd1,3'd4,3'd0,3'd0,1'b0,1'b0,
                            16'hFFFB, 16'hFFFD, 8'hEF, A1, A1, 1'b0,1'b0,1'b0,1'b0,1'b0});
    step("rw_idle", tmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
